rtc_apb_arbiter: RTL and testbench
==================================

// Module: rtc_apb_arbiter
// PURPOSE
//  APB master that shares the RTC slave's APB port between NUM_REQ requesters, e.g. host CPU and alarm service.
//  Each command (set time 0x00, add alarm 0x04, add/sub time 0x08, read) is accepted from one requester,
//  run as a SETUP/ACCESS APB transfer, and completed with a one-cycle response to that requester.
//  Grants rotate round-robin. A hung slave is broken by a timeout.
// PARAMETERS
//  NUM_REQ      2   number of requesters (2..8)
//  TIMEOUT_CYC  64  max ACCESS cycles waiting for pready before abort (>=1)
// PORTS
//  pclk       in   1           APB clock; all logic on posedge
//  preset     in   1           synchronous, active-high reset
//  req_valid  in   NUM_REQ     per-requester command valid; hold until req_ready
//  req_write  in   NUM_REQ     1=write, 0=read
//  req_addr   in   NUM_REQ*8   flattened; slice i = [8*i+:8]
//  req_wdata  in   NUM_REQ*32  flattened; slice i = [32*i+:32]
//  req_ready  out  NUM_REQ     one-hot accept pulse
//  rsp_valid  out  NUM_REQ     one-hot completion pulse
//  rsp_rdata  out  32          read data; valid with rsp_valid
//  rsp_err    out  1           1 = timeout or illegal write address; valid with rsp_valid
//  busy       out  1           high in any state other than IDLE
//  paddr      out  8           APB address
//  psel       out  1           APB select
//  penable    out  1           APB enable
//  pwrite     out  1           APB direction
//  pwdata     out  32          APB write data
//  pready     in   1           slave ready
//  prdata     in   32          slave read data
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, rr_ptr = NUM_REQ-1 (requester 0 has top priority).
//  FSM states: IDLE, SETUP, ACCESS, RESP.
//  IDLE
//   - If any req_valid: grant g = first valid index scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//   - req_ready[g]=1 in this cycle (combinational from state, req_valid and rr_ptr).
//   - Latch write/addr/wdata of g into paddr/pwrite/pwdata.
//   - Legal write addresses are 0x00, 0x04, 0x08. A write to any other address goes straight to RESP
//     with err=1 and no APB cycle. Reads are legal at any address.
//   - Otherwise go to SETUP.
//  SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
//  ACCESS
//   - psel=1, penable=1; paddr, pwrite and pwdata stay stable; timer counts from 0.
//   - pready=1 at a posedge: capture prdata (reads only, else 0), err=0, go to RESP.
//   - Timer reaches TIMEOUT_CYC with pready still 0: err=1, rdata=0, go to RESP.
//  RESP
//   - psel=penable=0; rsp_valid[g]=1 for one cycle with rsp_rdata and rsp_err; rr_ptr<=g; go to IDLE.
//  Output hold: rsp_rdata and rsp_err hold until the next RESP. rsp_valid is 0 outside RESP.
//  Latency with zero-wait pready:
//   - accept in cycle N; SETUP N+1; ACCESS N+2; rsp_valid N+3.
//   - Throughput is one transfer per 4 cycles.
//  Boundary conditions
//   - req_valid dropped before being granted: the request is ignored; no response.
//   - New req_valid during busy: not accepted; it is arbitrated at the next IDLE.
//   - All requesters valid: strict rotation, each served once per NUM_REQ grants.
//   - Reset mid-transfer: psel and penable are 0 after the next edge, no rsp_valid, pointer resets.
//   - Timer counts ACCESS cycles only and clears on entry to ACCESS.
// TESTING
//  1. After reset, req0 writes 0x00 with wdata 0x04104041, pready tied 1
//     -> req_ready[0] pulses once, psel rises at N+1, penable at N+2, pwdata = 0x04104041,
//        rsp_valid[0] at N+3 with err=0.
//  2. req1 reads with prdata = 0x0430C000 and pready delayed 3 cycles
//     -> ACCESS lasts 4 cycles, rsp_rdata = 0x0430C000, rsp_valid[1] only.
//  3. req0 and req1 both valid continuously, 4 transfers
//     -> grant order 0, 1, 0, 1; no two psel windows overlap.
//  4. pready held 0 -> rsp_err=1 exactly TIMEOUT_CYC=64 cycles after ACCESS entry; psel drops in RESP.
//  5. req0 writes 0x0C -> rsp_err=1 at N+1; psel never asserts.
//  6. Assert preset during ACCESS of a write to 0x08
//     -> psel and penable are 0 the next cycle, no rsp_valid; the next grant goes to req0.

Source files
------------

// File: rtl/rtc_apb_arbiter.sv
// Round-robin APB master sharing one RTC slave between NUM_REQ requesters.
// Each accepted command runs one SETUP/ACCESS transfer and returns a one-cycle response.
module rtc_apb_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*8-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [7:0]            paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  input  logic                  pready,
  input  logic [31:0]           prdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [7:0]         paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               scan_hit;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   cand;
  logic               sel_write;
  logic [7:0]         sel_addr;
  logic [31:0]        sel_wdata;

  function automatic logic wr_addr_ok(input logic [7:0] a);
    return (a == 8'h00) || (a == 8'h04) || (a == 8'h08);
  endfunction

  // Scan starts just after the last served requester, so the most recent winner ranks last.
  always_comb begin
    scan_hit  = 1'b0;
    scan_idx  = '0;
    cand      = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!scan_hit && req_valid[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[8*i +: 8];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    tmr_d       = tmr_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (scan_hit) begin
          gnt_d    = scan_idx;
          paddr_d  = sel_addr;
          pwrite_d = sel_write;
          pwdata_d = sel_wdata;
          if (sel_write && !wr_addr_ok(sel_addr)) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        tmr_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // A pready on the final allowed cycle still completes normally.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? 32'h0 : prdata;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RESP: begin
        rr_ptr_d = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      tmr_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      tmr_q       <= tmr_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && scan_hit && (scan_idx == IDX_W'(i));
      rsp_valid[i] = (state_q == RESP) && (gnt_q == IDX_W'(i));
    end
  end

  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign busy      = (state_q != IDLE);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rtc_apb_arbiter.sv
// Scoreboard bench for rtc_apb_arbiter: a transaction-level round-robin model predicts
// grant order and responses; a negedge monitor compares whatever the DUT presents.
module tb_rtc_apb_arbiter;
  localparam int NR   = 2;
  localparam int TO   = 64;
  localparam logic [7:0] HANG = 8'hEE;

  typedef struct {
    int          idx;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        ill;
    logic        hang;
  } txn_t;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic [NR-1:0]    req_valid = '0, req_write = '0;
  logic [NR*8-1:0]  req_addr = '0;
  logic [NR*32-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [31:0]      rsp_rdata, pwdata, prdata;
  logic             rsp_err, busy, psel, penable, pwrite, pready;
  logic [7:0]       paddr;

  always #5 pclk = ~pclk;

  rtc_apb_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata));

  // Slave: programmable wait states, data derived from the address, never ready at HANG.
  int          fixed_wait = -1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr = '0;
  logic [2:0]  wait_q = '0;

  function automatic logic [31:0] slave_data(input logic [7:0] a);
    return {a, a ^ 8'hA5, ~a, 8'h3C};
  endfunction

  always @(posedge pclk) begin
    if (psel && !penable) wait_q <= (fixed_wait >= 0) ? 3'(fixed_wait) : 3'($urandom_range(0, 4));
    else if (psel && penable && wait_q != 0) wait_q <= wait_q - 3'd1;
  end
  assign pready = psel && penable && (wait_q == 3'd0) && (paddr != HANG);
  assign prdata = ovr_en ? ovr : slave_data(paddr);

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int   checks = 0, passes = 0;
  txn_t exp_q[$];
  int   rr_m = NR - 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endfunction

  function automatic void tmo(input string nm);
    checks++;
    $display("FAIL %s: got wait bound expired required completion", nm);
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic txn_t model(input txn_t c, input int i);
    txn_t t;
    t       = c;
    t.idx   = i;
    t.ill   = c.wr && !(c.addr == 8'h00 || c.addr == 8'h04 || c.addr == 8'h08);
    t.hang  = (c.addr == HANG);
    t.err   = t.ill || t.hang;
    t.rdata = (t.err || c.wr) ? 32'h0 : (ovr_en ? ovr : slave_data(c.addr));
    return t;
  endfunction

  // Monitor
  logic granted = 1'b0, pen_prev = 1'b0;
  int   acc_cnt = 0, psel_cnt = 0, t_rdy = 0, t_setup = 0, t_acc = 0, t_rsp = 0;

  always @(negedge pclk) begin
    if (preset) begin
      granted  = 1'b0;
      pen_prev = 1'b0;
      acc_cnt  = 0;
    end else begin
      if (psel) psel_cnt++;
      if (psel && !penable) begin acc_cnt = 0; t_setup = cyc; end
      if (psel && penable) begin
        if (!pen_prev) t_acc = cyc;
        acc_cnt++;
      end
      pen_prev = penable;
      if (penable && !psel) chk("penable_without_psel", 32'(psel), 32'd1);
      if (req_ready != '0) begin
        t_rdy = cyc;
        if (exp_q.size() == 0 || granted) chk("unexpected_grant", 32'(req_ready), 32'd0);
        else begin
          chk("grant", 32'(req_ready), 32'(onehot(exp_q[0].idx)));
          granted = 1'b1;
        end
      end
      if (psel && penable && pready) begin
        if (exp_q.size() == 0) chk("unexpected_apb", 32'(psel), 32'd0);
        else if (exp_q[0].ill) chk("apb_on_illegal_write", 32'(psel), 32'd0);
        else begin
          chk("paddr", 32'(paddr), 32'(exp_q[0].addr));
          chk("pwrite", 32'(pwrite), 32'(exp_q[0].wr));
          if (exp_q[0].wr) chk("pwdata", pwdata, exp_q[0].wdata);
        end
      end
      if (rsp_valid != '0) begin
        t_rsp = cyc;
        chk("psel_in_resp", 32'(psel), 32'd0);
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(onehot(t.idx)));
          chk("rsp_err", 32'(rsp_err), 32'(t.err));
          if (!t.ill) chk("rsp_rdata", rsp_rdata, t.rdata);
          if (t.hang && !t.ill) chk("timeout_len", 32'(acc_cnt), 32'(TO));
          granted = 1'b0;
        end
      end
    end
  end

  // Driver
  txn_t cmd_a[NR][4];
  int   cmd_n[NR];
  int   hd[NR];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (hd[i] < cmd_n[i]) begin
        req_valid[i]          = 1'b1;
        req_write[i]          = cmd_a[i][hd[i]].wr;
        req_addr[8*i +: 8]    = cmd_a[i][hd[i]].addr;
        req_wdata[32*i +: 32] = cmd_a[i][hd[i]].wdata;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic logic pending();
    for (int i = 0; i < NR; i++) if (hd[i] < cmd_n[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge pclk); n++; end
    if (busy) tmo("wait_idle");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin @(negedge pclk); n++; end
    if (exp_q.size() > 0) tmo("drain");
    @(negedge pclk);
  endtask

  // Each requester presents its command list in order; the model serves pending
  // requesters in rotation starting after the last one served.
  task automatic run_batch();
    int hm[NR];
    int rem = 0, rr, n;
    logic [NR-1:0] got;
    for (int i = 0; i < NR; i++) begin hm[i] = 0; hd[i] = 0; rem += cmd_n[i]; end
    wait_idle();
    rr = rr_m;
    while (rem > 0) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (rr + k) % NR;
        if (hm[idx] < cmd_n[idx]) begin
          exp_q.push_back(model(cmd_a[idx][hm[idx]], idx));
          hm[idx]++;
          rr = idx;
          rem--;
          break;
        end
      end
    end
    rr_m = rr;
    @(posedge pclk); #1;
    drive();
    n = 0;
    while (pending() && n < 4000) begin
      @(negedge pclk);
      got = req_ready;
      @(posedge pclk); #1;
      for (int i = 0; i < NR; i++) if (got[i] && hd[i] < cmd_n[i]) hd[i]++;
      drive();
      n++;
    end
    if (pending()) tmo("batch_grants");
    drain();
    for (int i = 0; i < NR; i++) cmd_n[i] = 0;
  endtask

  task automatic add_cmd(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d);
    cmd_a[i][cmd_n[i]].wr    = wr;
    cmd_a[i][cmd_n[i]].addr  = a;
    cmd_a[i][cmd_n[i]].wdata = d;
    cmd_n[i]++;
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 8'h00;
      1: return 8'h04;
      2: return 8'h08;
      3: return 8'h0C;
      4: return HANG;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    txn_t c;
    for (int i = 0; i < NR; i++) cmd_n[i] = 0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("rst_psel", 32'(psel), 0);       chk("rst_penable", 32'(penable), 0);
    chk("rst_busy", 32'(busy), 0);       chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0); chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);  chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", pwdata, 0);        chk("rst_pwrite", 32'(pwrite), 0);

    // Zero-wait write from requester 0: accept N, SETUP N+1, ACCESS N+2, response N+3.
    fixed_wait = 0;
    add_cmd(0, 1'b1, 8'h00, 32'h04104041);
    run_batch();
    chk("t1_setup_lat", 32'(t_setup - t_rdy), 1);
    chk("t1_access_lat", 32'(t_acc - t_rdy), 2);
    chk("t1_rsp_lat", 32'(t_rsp - t_rdy), 3);
    chk("t1_pwdata", pwdata, 32'h04104041);

    // Read with three wait states.
    fixed_wait = 3; ovr_en = 1'b1; ovr = 32'h0430C000;
    add_cmd(1, 1'b0, 8'h10, 32'h0);
    run_batch();
    chk("t2_access_len", 32'(t_rsp - t_acc), 4);
    ovr_en = 1'b0;
    repeat (3) @(negedge pclk);
    chk("t2_rdata_hold", rsp_rdata, 32'h0430C000);

    // Both requesters continuously valid: strict alternation.
    fixed_wait = 0;
    add_cmd(0, 1'b0, 8'h00, 0); add_cmd(0, 1'b0, 8'h04, 0);
    add_cmd(1, 1'b1, 8'h04, 32'hA5A50001); add_cmd(1, 1'b1, 8'h08, 32'h5A5A0002);
    run_batch();

    // Slave never ready.
    add_cmd(0, 1'b0, HANG, 0);
    run_batch();
    chk("t4_timeout_at", 32'(t_rsp - t_acc), 32'(TO));
    chk("t4_err", 32'(rsp_err), 1);

    // Illegal write address: immediate error response, no APB activity.
    p0 = psel_cnt;
    add_cmd(0, 1'b1, 8'h0C, 32'hDEADBEEF);
    run_batch();
    chk("t5_rsp_lat", 32'(t_rsp - t_rdy), 1);
    chk("t5_no_psel", 32'(psel_cnt - p0), 0);

    // Request withdrawn before it is granted draws no response.
    fixed_wait = 5;
    c.wr = 1'b0; c.addr = 8'h20; c.wdata = 0;
    exp_q.push_back(model(c, 1)); rr_m = 1;
    @(posedge pclk); #1;
    req_valid = 2'b10; req_write = 2'b00; req_addr = 16'h2000;
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge pclk); n++; end
    if (req_ready[1] !== 1'b1) tmo("withdraw_grant");
    @(posedge pclk); #1;
    req_valid = 2'b01; req_addr = 16'h0030;
    @(posedge pclk); #1;
    req_valid = 2'b00;
    drain();
    repeat (4) @(negedge pclk);
    chk("withdraw_idle", 32'(busy), 0);

    // Reset during ACCESS of a write to 0x08, after requester 0 was last served.
    fixed_wait = 0;
    add_cmd(0, 1'b0, 8'h04, 0);
    run_batch();
    fixed_wait = 7;
    c.wr = 1'b1; c.addr = 8'h08; c.wdata = 32'h12345678;
    exp_q.push_back(model(c, 1));
    @(posedge pclk); #1;
    req_valid = 2'b10; req_write = 2'b10; req_addr = 16'h0800; req_wdata = {32'h12345678, 32'h0};
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge pclk); n++; end
    if (req_ready[1] !== 1'b1) tmo("t6_grant");
    @(posedge pclk); #1;
    req_valid = 2'b00;
    n = 0;
    while (!(psel && penable) && n < 50) begin @(negedge pclk); n++; end
    if (!(psel && penable)) tmo("t6_access");
    @(posedge pclk); #1;
    preset = 1'b1;
    exp_q.delete();
    @(posedge pclk);
    @(negedge pclk);
    chk("t6_psel", 32'(psel), 0);
    chk("t6_penable", 32'(penable), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    @(posedge pclk); #1;
    preset = 1'b0;
    rr_m = NR - 1;
    @(negedge pclk);
    chk("t6_no_rsp_after", 32'(rsp_valid), 0);
    fixed_wait = 0;
    add_cmd(0, 1'b0, 8'h00, 0);
    add_cmd(1, 1'b0, 8'h04, 0);
    run_batch();

    // Randomized batches with random wait states.
    fixed_wait = -1;
    for (int b = 0; b < 30; b++) begin
      logic [NR-1:0] mask;
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        if (mask[i]) begin
          int cnt;
          cnt = $urandom_range(1, 3);
          for (int k = 0; k < cnt; k++) add_cmd(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
      run_batch();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
